fir_serial_ctrl: RTL and testbench

Time-multiplexed sequencer for the 32-tap low-pass FIR. It accepts one 16-bit sample per handshake and stores it in a 32-entry circular sample buffer. A single 16x20 multiply-accumulate is then stepped through all 32 taps under FSM control, and one rounded 16-bit result is emitted per accepted sample. It is the area-reduced alternative to the fully parallel FIR and sits between the sample source and the FIR output consumer with the same data/output port semantics.

---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_sample_buf.sv | 25 ++
 rtl/fir_serial_ctrl.sv | 127 ++++++++++++
 tb/tb_fir_serial_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, coefficient table, FSM state type and output rounding
// for the time-multiplexed 32-tap low-pass FIR.
package fir_pkg;

  localparam int NTAP = 32;             // number of taps (fixed coefficient set)
  localparam int DW   = 16;             // sample / output width
  localparam int CW   = 20;             // coefficient width
  localparam int AW   = 41;             // accumulator width
  localparam int PW   = DW + CW;        // full product width
  localparam int IW   = $clog2(NTAP);   // tap / buffer index width
  localparam int FW   = $clog2(NTAP + 1); // fill counter width (0..NTAP)

  // Rounding: take acc[31:16], add one when the accumulator is negative.
  localparam int ROUND_MSB  = 31;
  localparam int ROUND_LSB  = 16;
  localparam int ROUND_SIGN = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Symmetric low-pass coefficients; tap 0 multiplies the newest sample.
  localparam logic signed [CW-1:0] C [NTAP] = '{
    20'shFFF9E, 20'shFFF86, 20'shFFFA7, 20'sh0003B,
    20'sh0014B, 20'sh0024A, 20'sh00222, 20'shFFFE4,
    20'shFFBC5, 20'shFF7CA, 20'shFF74E, 20'shFFD74,
    20'sh00B1A, 20'sh01DAC, 20'sh02F9E, 20'sh03AA9,
    20'sh03AA9, 20'sh02F9E, 20'sh01DAC, 20'sh00B1A,
    20'shFFD74, 20'shFF74E, 20'shFF7CA, 20'shFFBC5,
    20'shFFFE4, 20'sh00222, 20'sh0024A, 20'sh0014B,
    20'sh0003B, 20'shFFFA7, 20'shFFF86, 20'shFFF9E
  };

  // Reduce the full accumulator to a 16-bit result (wraps, no saturation).
  function automatic logic [DW-1:0] round_acc(input logic signed [AW-1:0] a);
    return a[ROUND_MSB:ROUND_LSB] + DW'(a[ROUND_SIGN]);
  endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// 32x16 sample register file: one synchronous write port, one
// combinational read port.
module fir_sample_buf
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [NTAP];

  // Store the accepted sample at the write pointer.
  // NOTE: no reset on the storage array; warm-up suppression in the
  // controller ensures stale contents never reach the output.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_serial_ctrl.sv
// Serial FIR sequencer: accepts one sample, steps a single MAC through
// all 32 taps, emits one rounded result per accepted sample.
module fir_serial_ctrl
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  output logic          data_ready,
  output logic [DW-1:0] fir_d,
  output logic          fir_valid,
  output logic          ovf
);

  state_e               state_q, state_d;
  logic [IW-1:0]        wp_q, wp_d;
  logic [IW-1:0]        base_q, base_d;
  logic [IW-1:0]        k_q, k_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        res_q, res_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [IW-1:0]        rd_addr;
  logic [DW-1:0]        rd_data;
  logic signed [DW-1:0] rd_sample;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;

  assign data_ready = (state_q == IDLE);
  assign accept     = data_valid & data_ready;

  // Tap k reads the sample k positions older than the newest; wraps mod 32.
  assign rd_addr   = base_q - k_q;
  assign rd_sample = rd_data;
  assign prod      = rd_sample * C[k_q];
  assign acc_sum   = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

  fir_sample_buf u_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wp_q),
    .wdata_i (data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Next-state logic for the FSM, pointers, accumulator and output strobe.
  // NOTE: every _d signal gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    base_d  = base_q;
    k_d     = k_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    res_d   = '0;
    valid_d = 1'b0;
    ovf_d   = ovf_q | (data_valid & ~data_ready);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          base_d  = wp_q;
          wp_d    = wp_q + IW'(1);
          acc_d   = '0;
          k_d     = '0;
          if (fill_q != FW'(NTAP)) fill_d = fill_q + FW'(1);
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + IW'(1);
        if (k_q == IW'(NTAP - 1)) begin
          state_d = DONE;
          if (fill_q == FW'(NTAP)) begin
            valid_d = 1'b1;
            res_d   = round_acc(acc_sum);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      base_q  <= '0;
      k_q     <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      base_q  <= base_d;
      k_q     <= k_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fir_d     = res_q;
  assign fir_valid = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: reference convolution model
// feeding a scoreboard queue, popped when the result cycle arrives.
module tb_fir_serial_ctrl;

  logic        clk;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic        data_ready;
  logic [15:0] fir_d;
  logic        fir_valid;
  logic        ovf;

  fir_serial_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .fir_d      (fir_d),
    .fir_valid  (fir_valid),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit          v;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] hist[32];
  int          n_acc;
  int          n_checks;
  int          n_pass;
  bit          last_strobe;

  // Coefficients C00..C15; C16..C31 mirror them.
  logic [19:0] coef_hex[16] = '{
    20'hFFF9E, 20'hFFF86, 20'hFFFA7, 20'h0003B, 20'h0014B, 20'h0024A,
    20'h00222, 20'hFFFE4, 20'hFFBC5, 20'hFF7CA, 20'hFF74E, 20'hFFD74,
    20'h00B1A, 20'h01DAC, 20'h02F9E, 20'h03AA9
  };

  function automatic int coef(input int k);
    int idx;
    idx = (k < 16) ? k : 31 - k;
    return int'($signed(coef_hex[idx]));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: shift history, convolve, round, push expectation.
  task automatic model_push(input logic [15:0] x);
    longint      acc;
    logic [40:0] a;
    exp_t        e;
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    if (n_acc < 32) n_acc++;
    acc = 0;
    for (int k = 0; k < 32; k++)
      acc += longint'($signed(hist[k])) * longint'(coef(k));
    a   = acc[40:0];
    e.v = (n_acc == 32);
    e.d = e.v ? (a[31:16] + {15'd0, a[40]}) : 16'h0000;
    exp_q.push_back(e);
  endtask

  // Drive one sample; optionally pulse data_valid (ovf_at) or rst (rst_at)
  // in cycle T+n after the accept edge T.
  task automatic send(input logic [15:0] x, input int ovf_at, input int rst_at,
                      output logic [15:0] got);
    int   waited;
    int   strobes;
    bit   ready_hi;
    bit   d_stray;
    exp_t e;
    got    = '0;
    waited = 0;
    while (data_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", data_ready, 1);
    data = x;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    data = '0;
    model_push(x);
    strobes  = 0;
    ready_hi = 0;
    d_stray  = 0;
    e        = '0;
    for (int c = 1; c <= 33; c++) begin
      if (c == ovf_at) begin
        data_valid = 1'b1;
        data = 16'h7FFF;
      end
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (data_ready) ready_hi = 1;
      if (fir_valid) strobes++;
      if (ovf_at != 0 && c == ovf_at + 1) check("ovf_set_next_cycle", ovf, 1);
      if (c == 33) begin
        e   = exp_q.pop_front();
        got = fir_d;
        check("fir_valid_at_T33", fir_valid, e.v);
        check("fir_d_at_T33", fir_d, e.d);
      end else if (fir_d !== 16'h0) begin
        d_stray = 1;
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      data = '0;
      if (c == rst_at) begin
        rst = 1'b0;
        void'(exp_q.pop_front());
        n_acc = 0;
        check("abort_data_ready", data_ready, 1);
        check("abort_fir_valid", fir_valid, 0);
        check("abort_fir_d", fir_d, 0);
        check("abort_ovf", ovf, 0);
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (fir_valid) strobes++;
          @(posedge clk); #1;
        end
        check("no_valid_after_abort", strobes, 0);
        last_strobe = 0;
        return;
      end
    end
    check("ready_low_T1_T33", ready_hi, 0);
    check("fir_d_zero_off_strobe", d_stray, 0);
    check("strobe_count", strobes, e.v);
    check("ready_at_T34", data_ready, 1);
    last_strobe = (strobes == 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    n_checks    = 0;
    n_pass      = 0;
    n_acc       = 0;
    last_strobe = 0;
    for (int i = 0; i < 32; i++) hist[i] = '0;
    rst = 1'b1;
    data_valid = 1'b0;
    data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_data_ready", data_ready, 1);
    check("reset_fir_valid", fir_valid, 0);
    check("reset_fir_d", fir_d, 0);
    check("reset_ovf", ovf, 0);

    // Impulse through warm-up.
    for (int i = 0; i < 31; i++) send(16'h0000, 0, 0, got);
    send(16'h4000, 0, 0, got);
    check("impulse_tap0", got, 16'hFFE8);
    check("first_valid_on_32nd", last_strobe, 1);
    send(16'h0000, 0, 0, got);
    check("impulse_tap1", got, 16'hFFE2);

    // DC positive.
    for (int i = 0; i < 32; i++) send(16'h1000, 0, 0, got);
    check("dc_pos", got, 16'h0FFF);
    send(16'h1000, 0, 0, got);
    check("dc_pos_again", got, 16'h0FFF);

    // DC negative.
    for (int i = 0; i < 32; i++) send(16'hF000, 0, 0, got);
    check("dc_neg", got, 16'hF001);

    // Dropped sample during MAC cycle 5; result and pointers unaffected.
    send(16'($urandom), 6, 0, got);
    for (int i = 0; i < 3; i++) send(16'($urandom), 0, 0, got);
    check("ovf_sticky", ovf, 1);

    // Reset at MAC cycle 10, then warm-up again.
    send(16'($urandom), 0, 11, got);
    for (int i = 0; i < 31; i++) begin
      send(16'($urandom), 0, 0, got);
      if (i == 30) check("no_valid_31st_after_abort", last_strobe, 0);
    end
    send(16'($urandom), 0, 0, got);
    check("valid_32nd_after_abort", last_strobe, 1);
    send(16'($urandom), 0, 0, got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
